// File: rtl/commit_ctrl_pkg.sv
// commit_ctrl_pkg
//   Shared encodings for the in-order commit controller: the ROB head
//   instruction kinds and the controller states.
package commit_ctrl_pkg;

   // Instruction kind carried by the ROB head entry.
   typedef enum logic [1:0] {
      KIND_REG    = 2'd0,
      KIND_STORE  = 2'd1,
      KIND_BRANCH = 2'd2,
      KIND_HALT   = 2'd3
   } kind_e;

   // Commit controller states.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

endpackage : commit_ctrl_pkg

// File: rtl/commit_ctrl.sv
// commit_ctrl
//   In-order retirement controller sitting between the ROB head and the
//   register file write port. At most one head entry retires per cycle.
//   Register results go to the regfile, stores are released to the LSB,
//   and a mispredicted branch produces a one-cycle flush pulse plus a PC
//   redirect, followed by a quiet window of FLUSH_CYCLES cycles with no
//   commits. A halt entry parks the controller until reset.
//
// Ports
//   clk_in, rst_in                 clock, synchronous active-high reset
//   from_rob_head_*                ROB head entry (valid/ready/kind/ids/data/branch info)
//   from_lsb_store_ready           LSB can accept a store commit this cycle
//   to_rob_pop                     combinational: head retires this cycle
//   to_regfile_*                   registered regfile write (1-cycle after pop)
//   to_lsb_store_*                 registered store-commit pulse and ROB id
//   flush_output                   registered one-cycle pipeline flush pulse
//   to_ifetch_redirect_*           registered redirect, coincident with flush
//   halted                         sticky halt indication
//   commit_count                   retired-instruction counter (wraps)
module commit_ctrl
   import commit_ctrl_pkg::*;
#(
   parameter int ROB_WIDTH    = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 from_rob_head_valid,
   input  logic                 from_rob_head_ready,
   input  logic [1:0]           from_rob_head_kind,
   input  logic [ROB_WIDTH-1:0] from_rob_head_rob_id,
   input  logic [4:0]           from_rob_head_reg_id,
   input  logic [31:0]          from_rob_head_data,
   input  logic                 from_rob_head_mispredict,
   input  logic [31:0]          from_rob_head_target,
   input  logic                 from_lsb_store_ready,
   output logic                 to_rob_pop,
   output logic                 to_regfile_write_enabled,
   output logic [4:0]           to_regfile_reg_id,
   output logic [31:0]          to_regfile_data,
   output logic [ROB_WIDTH-1:0] to_regfile_rob_id,
   output logic                 to_lsb_store_commit,
   output logic [ROB_WIDTH-1:0] to_lsb_store_rob_id,
   output logic                 flush_output,
   output logic                 to_ifetch_redirect_valid,
   output logic [31:0]          to_ifetch_redirect_pc,
   output logic                 halted,
   output logic [31:0]          commit_count
);

   // Counter must be able to hold FLUSH_CYCLES itself (it counts down to 0).
   localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

   state_e           state;
   logic [CNT_W-1:0] flush_cnt;
   kind_e            head_kind;
   logic             commit;

   assign head_kind = kind_e'(from_rob_head_kind);

   // A store may only retire when the LSB can take it; every other kind
   // retires as soon as its result is ready. No retirement outside RUN.
   assign commit = (state == ST_RUN) && from_rob_head_valid && from_rob_head_ready &&
                   ((head_kind != KIND_STORE) || from_lsb_store_ready);

   assign to_rob_pop = commit;

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values; blocking assignments would let later
   // statements see half-updated state and break the 1-cycle output timing.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state                    <= ST_RUN;
         flush_cnt                <= '0;
         to_regfile_write_enabled <= 1'b0;
         to_regfile_reg_id        <= '0;
         to_regfile_data          <= '0;
         to_regfile_rob_id        <= '0;
         to_lsb_store_commit      <= 1'b0;
         to_lsb_store_rob_id      <= '0;
         flush_output             <= 1'b0;
         to_ifetch_redirect_valid <= 1'b0;
         to_ifetch_redirect_pc    <= '0;
         halted                   <= 1'b0;
         commit_count             <= '0;
      end else begin
         // Strobes default low so each one is a single-cycle pulse; the
         // data fields beside them simply hold their last value.
         to_regfile_write_enabled <= 1'b0;
         to_lsb_store_commit      <= 1'b0;
         flush_output             <= 1'b0;
         to_ifetch_redirect_valid <= 1'b0;

         case (state)
            ST_RUN: begin
               if (commit) begin
                  commit_count <= commit_count + 32'd1;
                  case (head_kind)
                     KIND_REG: begin
                        // x0 is hardwired: retire the entry but suppress the write.
                        if (from_rob_head_reg_id != 5'd0) begin
                           to_regfile_write_enabled <= 1'b1;
                           to_regfile_reg_id        <= from_rob_head_reg_id;
                           to_regfile_data          <= from_rob_head_data;
                           to_regfile_rob_id        <= from_rob_head_rob_id;
                        end
                     end
                     KIND_STORE: begin
                        to_lsb_store_commit <= 1'b1;
                        to_lsb_store_rob_id <= from_rob_head_rob_id;
                     end
                     KIND_BRANCH: begin
                        if (from_rob_head_mispredict) begin
                           flush_output             <= 1'b1;
                           to_ifetch_redirect_valid <= 1'b1;
                           to_ifetch_redirect_pc    <= from_rob_head_target;
                           state                    <= ST_FLUSH;
                           flush_cnt                <= CNT_W'(FLUSH_CYCLES);
                        end
                     end
                     KIND_HALT: begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end

            // The pulse cycle is spent here with the loaded count, then
            // FLUSH_CYCLES further quiet cycles before RUN resumes.
            ST_FLUSH: begin
               if (flush_cnt == '0) begin
                  state <= ST_RUN;
               end else begin
                  flush_cnt <= flush_cnt - CNT_W'(1);
               end
            end

            ST_HALT: ;  // absorbing until reset

            default: state <= ST_RUN;
         endcase
      end
   end

endmodule : commit_ctrl

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl
//   Directed bench for commit_ctrl: a table of single-cycle RUN-state
//   vectors with hand-computed expectations, then hand-written sequences
//   for the flush window, reset inside a flush, and halt.
module tb_commit_ctrl;

   localparam int RW = 4;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          head_valid;
   logic          head_ready;
   logic [1:0]    head_kind;
   logic [RW-1:0] head_rob_id;
   logic [4:0]    head_reg_id;
   logic [31:0]   head_data;
   logic          head_mis;
   logic [31:0]   head_target;
   logic          store_ready;

   logic          rob_pop;
   logic          rf_we;
   logic [4:0]    rf_reg_id;
   logic [31:0]   rf_data;
   logic [RW-1:0] rf_rob_id;
   logic          st_commit;
   logic [RW-1:0] st_rob_id;
   logic          flush;
   logic          redir_valid;
   logic [31:0]   redir_pc;
   logic          halted;
   logic [31:0]   commit_count;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   commit_ctrl #(.ROB_WIDTH(RW), .FLUSH_CYCLES(2)) dut (
      .clk_in                   (clk_in),
      .rst_in                   (rst_in),
      .from_rob_head_valid      (head_valid),
      .from_rob_head_ready      (head_ready),
      .from_rob_head_kind       (head_kind),
      .from_rob_head_rob_id     (head_rob_id),
      .from_rob_head_reg_id     (head_reg_id),
      .from_rob_head_data       (head_data),
      .from_rob_head_mispredict (head_mis),
      .from_rob_head_target     (head_target),
      .from_lsb_store_ready     (store_ready),
      .to_rob_pop               (rob_pop),
      .to_regfile_write_enabled (rf_we),
      .to_regfile_reg_id        (rf_reg_id),
      .to_regfile_data          (rf_data),
      .to_regfile_rob_id        (rf_rob_id),
      .to_lsb_store_commit      (st_commit),
      .to_lsb_store_rob_id      (st_rob_id),
      .flush_output             (flush),
      .to_ifetch_redirect_valid (redir_valid),
      .to_ifetch_redirect_pc    (redir_pc),
      .halted                   (halted),
      .commit_count             (commit_count)
   );

   typedef struct {
      logic          valid;
      logic          ready;
      logic [1:0]    kind;
      logic [RW-1:0] rob_id;
      logic [4:0]    reg_id;
      logic [31:0]   data;
      logic          st_rdy;
      logic          e_pop;
      logic          e_we;
      logic          e_sc;
      logic [31:0]   e_count;
   } vec_t;

   vec_t vecs[11];

   function automatic vec_t mk(logic v, logic r, logic [1:0] k, logic [RW-1:0] rob,
                               logic [4:0] rg, logic [31:0] d, logic sr,
                               logic ep, logic ew, logic es, logic [31:0] ec);
      vec_t t;
      t.valid = v;  t.ready = r;  t.kind = k;  t.rob_id = rob;
      t.reg_id = rg; t.data = d;  t.st_rdy = sr;
      t.e_pop = ep; t.e_we = ew;  t.e_sc = es; t.e_count = ec;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive_head(input logic v, input logic r, input logic [1:0] k,
                             input logic [RW-1:0] rob, input logic [4:0] rg,
                             input logic [31:0] d, input logic m, input logic [31:0] tgt,
                             input logic sr);
      head_valid = v;  head_ready = r;  head_kind = k;  head_rob_id = rob;
      head_reg_id = rg; head_data = d;  head_mis = m;   head_target = tgt;
      store_ready = sr;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      // Table: vectors applied back to back from the post-reset state.
      vecs[0]  = mk(1, 1, 2'd0, 4'd3,  5'd5,  32'hDEADBEEF, 0, 1, 1, 0, 32'd1);
      vecs[1]  = mk(1, 1, 2'd0, 4'd4,  5'd0,  32'h12345678, 0, 1, 0, 0, 32'd2);
      vecs[2]  = mk(0, 1, 2'd0, 4'd5,  5'd6,  32'h00000066, 1, 0, 0, 0, 32'd2);
      vecs[3]  = mk(1, 0, 2'd0, 4'd5,  5'd6,  32'h00000066, 1, 0, 0, 0, 32'd2);
      vecs[4]  = mk(1, 1, 2'd1, 4'd7,  5'd0,  32'h0,        0, 0, 0, 0, 32'd2);
      vecs[5]  = mk(1, 1, 2'd1, 4'd7,  5'd0,  32'h0,        0, 0, 0, 0, 32'd2);
      vecs[6]  = mk(1, 1, 2'd1, 4'd7,  5'd0,  32'h0,        0, 0, 0, 0, 32'd2);
      vecs[7]  = mk(1, 1, 2'd1, 4'd7,  5'd0,  32'h0,        1, 1, 0, 1, 32'd3);
      vecs[8]  = mk(1, 1, 2'd0, 4'd15, 5'd31, 32'hA5A5A5A5, 0, 1, 1, 0, 32'd4);
      vecs[9]  = mk(1, 1, 2'd2, 4'd2,  5'd0,  32'h0,        0, 1, 0, 0, 32'd5);
      vecs[10] = mk(1, 1, 2'd0, 4'd1,  5'd1,  32'h00000001, 0, 1, 1, 0, 32'd6);

      // ---------------- reset ----------------
      rst_in = 1'b1;
      drive_head(0, 0, 2'd0, '0, '0, '0, 0, '0, 0);
      tick();
      tick();
      check("rst_we",     {31'd0, rf_we},       32'd0);
      check("rst_sc",     {31'd0, st_commit},   32'd0);
      check("rst_flush",  {31'd0, flush},       32'd0);
      check("rst_redir",  {31'd0, redir_valid}, 32'd0);
      check("rst_pc",     redir_pc,             32'd0);
      check("rst_halted", {31'd0, halted},      32'd0);
      check("rst_count",  commit_count,         32'd0);
      check("rst_data",   rf_data,              32'd0);
      @(negedge clk_in);
      rst_in = 1'b0;

      // ---------------- table vectors ----------------
      for (int i = 0; i < 11; i++) begin
         @(negedge clk_in);
         drive_head(vecs[i].valid, vecs[i].ready, vecs[i].kind, vecs[i].rob_id,
                    vecs[i].reg_id, vecs[i].data, 1'b0, 32'h0, vecs[i].st_rdy);
         #1;
         check($sformatf("v%0d_pop", i), {31'd0, rob_pop}, {31'd0, vecs[i].e_pop});
         tick();
         check($sformatf("v%0d_we", i),    {31'd0, rf_we},     {31'd0, vecs[i].e_we});
         check($sformatf("v%0d_sc", i),    {31'd0, st_commit}, {31'd0, vecs[i].e_sc});
         check($sformatf("v%0d_flush", i), {31'd0, flush},     32'd0);
         check($sformatf("v%0d_count", i), commit_count,       vecs[i].e_count);
         if (vecs[i].e_we) begin
            check($sformatf("v%0d_reg", i),  {27'd0, rf_reg_id}, {27'd0, vecs[i].reg_id});
            check($sformatf("v%0d_data", i), rf_data,            vecs[i].data);
            check($sformatf("v%0d_rob", i),  {28'd0, rf_rob_id}, {28'd0, vecs[i].rob_id});
         end
         if (vecs[i].e_sc) begin
            check($sformatf("v%0d_strob", i), {28'd0, st_rob_id}, {28'd0, vecs[i].rob_id});
         end
      end

      // ---------------- mispredict and flush window ----------------
      @(negedge clk_in);
      drive_head(1, 1, 2'd2, 4'd5, 5'd0, 32'h0, 1, 32'h00001000, 1);
      #1;
      check("mis_pop", {31'd0, rob_pop}, 32'd1);
      tick();
      check("mis_flush", {31'd0, flush},       32'd1);
      check("mis_redir", {31'd0, redir_valid}, 32'd1);
      check("mis_pc",    redir_pc,             32'h00001000);
      check("mis_we",    {31'd0, rf_we},       32'd0);
      check("mis_count", commit_count,         32'd7);
      // A ready register head waits through the pulse cycle and two quiet cycles.
      drive_head(1, 1, 2'd0, 4'd6, 5'd9, 32'h00000099, 0, 32'h0, 1);
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("fl%0d_pop", i), {31'd0, rob_pop}, 32'd0);
         tick();
         check($sformatf("fl%0d_flush", i), {31'd0, flush},       32'd0);
         check($sformatf("fl%0d_redir", i), {31'd0, redir_valid}, 32'd0);
         check($sformatf("fl%0d_we", i),    {31'd0, rf_we},       32'd0);
      end
      #1;
      check("resume_pop", {31'd0, rob_pop}, 32'd1);
      tick();
      check("resume_we",    {31'd0, rf_we}, 32'd1);
      check("resume_reg",   {27'd0, rf_reg_id}, 32'd9);
      check("resume_data",  rf_data,        32'h00000099);
      check("resume_count", commit_count,   32'd8);

      // ---------------- reset inside the flush window ----------------
      @(negedge clk_in);
      drive_head(1, 1, 2'd2, 4'd10, 5'd0, 32'h0, 1, 32'h00002000, 1);
      tick();
      check("rf_flush", {31'd0, flush}, 32'd1);
      @(negedge clk_in);
      drive_head(1, 1, 2'd0, 4'd11, 5'd12, 32'hCAFEF00D, 0, 32'h0, 1);
      rst_in = 1'b1;
      tick();
      @(negedge clk_in);
      rst_in = 1'b0;
      #1;
      check("rf_count", commit_count,         32'd0);
      check("rf_fl0",   {31'd0, flush},       32'd0);
      check("rf_rv0",   {31'd0, redir_valid}, 32'd0);
      check("rf_we0",   {31'd0, rf_we},       32'd0);
      check("rf_pop",   {31'd0, rob_pop},     32'd1);
      tick();
      check("rf_we1",    {31'd0, rf_we}, 32'd1);
      check("rf_data1",  rf_data,        32'hCAFEF00D);
      check("rf_count1", commit_count,   32'd1);

      // ---------------- halt ----------------
      @(negedge clk_in);
      drive_head(1, 1, 2'd3, 4'd8, 5'd0, 32'h0, 0, 32'h0, 1);
      #1;
      check("halt_pop", {31'd0, rob_pop}, 32'd1);
      tick();
      check("halt_halted", {31'd0, halted}, 32'd1);
      check("halt_count",  commit_count,    32'd2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_in);
         if (i == 2) drive_head(1, 1, 2'd2, 4'd9, 5'd0, 32'h0, 1, 32'h3000, 1);
         else        drive_head(1, 1, 2'd0, 4'd9, 5'd4, 32'h44, 0, 32'h0, 1);
         #1;
         check($sformatf("h%0d_pop", i), {31'd0, rob_pop}, 32'd0);
         tick();
         check($sformatf("h%0d_we", i),     {31'd0, rf_we},  32'd0);
         check($sformatf("h%0d_flush", i),  {31'd0, flush},  32'd0);
         check($sformatf("h%0d_halted", i), {31'd0, halted}, 32'd1);
         check($sformatf("h%0d_count", i),  commit_count,    32'd2);
      end
      @(negedge clk_in);
      drive_head(0, 0, 2'd0, '0, '0, '0, 0, '0, 0);
      rst_in = 1'b1;
      tick();
      check("hrst_halted", {31'd0, halted}, 32'd0);
      check("hrst_count",  commit_count,    32'd0);
      @(negedge clk_in);
      rst_in = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_commit_ctrl

// File: doc/commit_ctrl.md
Name: commit_ctrl

Overview:
In-order retirement controller between the ROB head and the register file write port. Each cycle it inspects the ROB head entry and retires it when ready. Register results go to the regfile; stores go to the LSB; branch mispredictions trigger a pipeline flush and PC redirect. It also sequences the post-flush quiet window and the halt condition.

Parameters:
ROB_WIDTH, 4, ROB id width. Id 0 is reserved as "no producer"; valid ids are 1..2^ROB_WIDTH-1.
FLUSH_CYCLES, 2, number of cycles after the flush pulse during which no commit occurs.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
from_rob_head_valid  input  1  ROB non-empty
from_rob_head_ready  input  1  head result available
from_rob_head_kind  input  2  0=reg write, 1=store, 2=branch, 3=halt
from_rob_head_rob_id  input  ROB_WIDTH  head ROB id
from_rob_head_reg_id  input  5  destination register
from_rob_head_data  input  32  result value
from_rob_head_mispredict  input  1  branch resolved wrong
from_rob_head_target  input  32  correct PC on mispredict
from_lsb_store_ready  input  1  LSB can accept a store commit this cycle
to_rob_pop  output  1  combinational; head retired this cycle
to_regfile_write_enabled  output  1  registered regfile write strobe
to_regfile_reg_id  output  5  registered
to_regfile_data  output  32  registered
to_regfile_rob_id  output  ROB_WIDTH  registered
to_lsb_store_commit  output  1  registered one-cycle pulse
to_lsb_store_rob_id  output  ROB_WIDTH  registered
flush_output  output  1  registered one-cycle pulse to regfile, ROB, RS, LSB
to_ifetch_redirect_valid  output  1  registered; coincident with flush_output
to_ifetch_redirect_pc  output  32  registered
halted  output  1  sticky
commit_count  output  32  retired-instruction counter

Behaviour:
- Single clock. rst_in is synchronous and active-high. Reset drives every registered output and commit_count to 0 and sets state to RUN; reset mid-flush or while halted also returns to RUN.
- States: RUN, FLUSH, HALT.
- commit condition (RUN only) = head_valid & head_ready & (kind!=1 | from_lsb_store_ready). to_rob_pop = commit condition.
- In states FLUSH and HALT, to_rob_pop = 0.
- Per-kind action on commit; registered outputs appear the cycle after pop (1-cycle latency):
  - kind 0: write_enabled=1 with reg_id, data and rob_id copied. write_enabled is forced to 0 when reg_id==0, but the pop still occurs.
  - kind 1: to_lsb_store_commit=1 with the head rob_id. If the head is a store and store_ready=0, stall with no pop.
  - kind 2, mispredict=0: pop only.
  - kind 2, mispredict=1: flush_output=1, redirect_valid=1, redirect_pc=target. Next state is FLUSH with the counter loaded to FLUSH_CYCLES.
  - kind 3: next state HALT; halted=1 from the following cycle.
- Strobes (write_enabled, store_commit, flush_output, redirect_valid) are high for exactly one cycle per commit. Data fields hold their last value.
- The flush pulse and a regfile write never coincide, because a branch commit produces no write. The regfile therefore still receives the prior cycle's write before it sees the flush.
- FLUSH: the counter decrements each cycle and the state returns to RUN when it reaches 0. Head inputs are ignored. FLUSH_CYCLES=0 returns to RUN on the next cycle.
- HALT: absorbing until reset. All strobes stay 0.
- commit_count increments by 1 on every pop, including rd=0 writes and mispredicted branches. It wraps modulo 2^32.
- At most one retirement per cycle.

Decomposition:
- Kind encodings (KIND_REG/STORE/BRANCH/HALT) and state encodings go in the shared const_def.v; the ROB id range reuses the existing ROB_RANGE define.
- No sub-module; a single always block for state plus registered outputs, and combinational pop logic.

Test Plan:
- Reset, then a kind-0 head with reg 5, data 0xDEADBEEF, rob 3, ready -> pop at cycle t; at t+1 write_enabled=1, reg_id=5, data=0xDEADBEEF, rob_id=3; commit_count=1.
- A kind-0 head with reg 0 -> pop=1, write_enabled stays 0, commit_count increments.
- A store head with rob 7 and store_ready=0 for 3 cycles, then 1 -> no pop for 3 cycles; pop on the 4th; store_commit pulse with rob_id 7 the next cycle.
- A branch head with mispredict=1 and target 0x1000 -> flush_output=1, redirect_pc=0x1000 for one cycle. With FLUSH_CYCLES=2 and ready heads present, there is no pop for the next 2 cycles, then commits resume.
- A halt head -> pop, halted=1 next cycle. Later ready heads are never popped. rst_in then clears halted and commit_count to 0.
- rst_in asserted during the FLUSH window -> the next cycle is in RUN with all strobes 0, and the first ready head commits immediately.
